// File: rtl/bsg_level_shift_iso_ctrl.sv
// Power-domain sequencer for an isolated, level-shifted data channel.
// Walks the rail through power-up, settle, drain and isolation, and owns the one-entry output register.
module bsg_level_shift_iso_ctrl #(
    parameter int width_p         = 128,
    parameter int settle_cycles_p = 8,
    parameter int iso_cycles_p    = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               pwr_on_req_i,
    input  logic               pwr_good_i,
    output logic               pwr_en_o,
    output logic               shift_en_o,
    output logic               on_o,
    output logic               error_o,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    localparam int max_cnt_lp = (settle_cycles_p > iso_cycles_p) ? settle_cycles_p : iso_cycles_p;
    localparam int cnt_w_lp   = (max_cnt_lp > 1) ? $clog2(max_cnt_lp) : 1;

    typedef enum logic [2:0] {
        e_off,
        e_pwr_up,
        e_settle,
        e_on,
        e_drain,
        e_iso
    } state_e;

    state_e               state_q, state_d;
    logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
    logic                 v_q, v_d;
    logic [width_p-1:0]   data_q, data_d;
    logic                 error_q, error_d;
    logic                 fault;

    assign pwr_en_o   = (state_q != e_off);
    assign shift_en_o = (state_q == e_on) || (state_q == e_drain);
    assign on_o       = (state_q == e_on);
    assign error_o    = error_q;
    assign v_o        = v_q;
    assign data_o     = data_q;
    assign ready_o    = (state_q == e_on) && (!v_q || ready_i);

    // Losing power-good once the rail is up drops everything and parks in OFF.
    assign fault = !pwr_good_i &&
                   ((state_q == e_settle) || (state_q == e_on) || (state_q == e_drain));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        data_d  = data_q;
        error_d = error_q;

        if (fault) begin
            state_d = e_off;
            v_d     = 1'b0;
            error_d = 1'b1;
        end else begin
            unique case (state_q)
                e_off: begin
                    if (pwr_on_req_i) state_d = e_pwr_up;
                end
                e_pwr_up: begin
                    if (!pwr_on_req_i) begin
                        state_d = e_off;
                    end else if (pwr_good_i) begin
                        state_d = e_settle;
                        cnt_d   = cnt_w_lp'(settle_cycles_p - 1);
                    end
                end
                e_settle: begin
                    if (!pwr_on_req_i)     state_d = e_off;
                    else if (cnt_q == '0)  state_d = e_on;
                    else                   cnt_d   = cnt_q - 1'b1;
                end
                e_on: begin
                    if (v_i && ready_o) begin
                        data_d = data_i;
                        v_d    = 1'b1;
                    end else if (ready_i) begin
                        v_d    = 1'b0;
                    end
                    if (!pwr_on_req_i) state_d = e_drain;
                end
                e_drain: begin
                    if (!v_q || ready_i) begin
                        state_d = e_iso;
                        v_d     = 1'b0;
                        cnt_d   = cnt_w_lp'(iso_cycles_p - 1);
                    end
                end
                e_iso: begin
                    if (cnt_q == '0) state_d = e_off;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = e_off;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_off;
            cnt_q   <= '0;
            v_q     <= 1'b0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

endmodule
